// File: rtl/reg_wb_arbiter.sv
// ---------------------------------------------------------------------------
// reg_wb_arbiter
//   Shares the register file's single write port between two writeback
//   requesters: port A (ALU) and port B (load/store unit). It also keeps a
//   per-register pending-write scoreboard so decode can detect RAW hazards.
//
//   Arbitration is round-robin over valid/ready handshakes. Each ready is
//   combinational from the valids and the round-robin pointer. The accepted
//   request reaches the registered write port one cycle later.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_valid/a_ready/a_rd/      port A (ALU) writeback request
//     a_data/a_mode
//   b_valid/b_ready/b_rd/      port B (load/store) writeback request
//     b_data/b_mode
//   rf_rc/rf_dataC/            registered register-file write port
//     rf_w_en/rf_w_mode
//   iss_valid/iss_rd           decode issued a writer of iss_rd
//   chk_ra/chk_rb              source registers to check
//   hazard_a/hazard_b          source register has a pending write
//   wb_err                     one-cycle pulse: accepted request had mode 3
//
// NUM_REGS is expected to equal 2**ADDR_LEN, so every address indexes a
// real scoreboard bit.
// ---------------------------------------------------------------------------
module reg_wb_arbiter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDR_LEN = 5,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                a_valid,
    output logic                a_ready,
    input  logic [ADDR_LEN-1:0] a_rd,
    input  logic [WIDTH-1:0]    a_data,
    input  logic [1:0]          a_mode,

    input  logic                b_valid,
    output logic                b_ready,
    input  logic [ADDR_LEN-1:0] b_rd,
    input  logic [WIDTH-1:0]    b_data,
    input  logic [1:0]          b_mode,

    output logic [ADDR_LEN-1:0] rf_rc,
    output logic [WIDTH-1:0]    rf_dataC,
    output logic                rf_w_en,
    output logic [1:0]          rf_w_mode,

    input  logic                iss_valid,
    input  logic [ADDR_LEN-1:0] iss_rd,
    input  logic [ADDR_LEN-1:0] chk_ra,
    input  logic [ADDR_LEN-1:0] chk_rb,
    output logic                hazard_a,
    output logic                hazard_b,

    output logic                wb_err
);

    localparam logic [1:0] ModeBad = 2'd3;

    // Which port wins the next tie.
    typedef enum logic {
        PrioA,
        PrioB
    } prio_e;

    prio_e               prio_q, prio_d;

    logic                a_grant, b_grant, xfer;
    logic [ADDR_LEN-1:0] x_rd;
    logic [WIDTH-1:0]    x_data;
    logic [1:0]          x_mode;

    logic                w_en_d, err_d;
    logic [ADDR_LEN-1:0] rc_q;
    logic [WIDTH-1:0]    data_q;
    logic [1:0]          mode_q;
    logic                w_en_q, err_q;

    logic [NUM_REGS-1:0] busy_q, busy_d;

    // ------------------------------------------------------------------
    // Arbitration and transfer selection
    // ------------------------------------------------------------------
    always_comb begin
        a_grant = a_valid & (~b_valid | (prio_q == PrioA));
        b_grant = b_valid & (~a_valid | (prio_q == PrioB));
        xfer    = a_grant | b_grant;

        x_rd   = a_grant ? a_rd   : b_rd;
        x_data = a_grant ? a_data : b_data;
        x_mode = a_grant ? a_mode : b_mode;

        // The pointer only moves on a grant.
        prio_d = prio_q;
        if (a_grant) begin
            prio_d = PrioB;
        end else if (b_grant) begin
            prio_d = PrioA;
        end

        // Writes to r0 and malformed mode-3 writes are accepted but dropped.
        w_en_d = xfer && (x_rd != '0) && (x_mode != ModeBad);
        err_d  = xfer && (x_mode == ModeBad);
    end

    assign a_ready = a_grant;
    assign b_ready = b_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= PrioA;
            w_en_q <= 1'b0;
            err_q  <= 1'b0;
            rc_q   <= '0;
            data_q <= '0;
            mode_q <= '0;
        end else begin
            prio_q <= prio_d;
            w_en_q <= w_en_d;
            err_q  <= err_d;
            // Address/data/mode only change on a real write; otherwise hold.
            if (w_en_d) begin
                rc_q   <= x_rd;
                data_q <= x_data;
                mode_q <= x_mode;
            end
        end
    end

    assign rf_rc     = rc_q;
    assign rf_dataC  = data_q;
    assign rf_w_mode = mode_q;
    assign rf_w_en   = w_en_q;
    assign wb_err    = err_q;

    // ------------------------------------------------------------------
    // Pending-write scoreboard
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        // Any accepted transfer retires its register, even a dropped mode-3 one.
        if (xfer) begin
            busy_d[x_rd] = 1'b0;
        end
        // Applied after the clear so a same-cycle new writer stays outstanding.
        if (iss_valid) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign hazard_a = busy_q[chk_ra];
    assign hazard_b = busy_q[chk_rb];

endmodule

// File: tb/tb_reg_wb_arbiter.sv
module tb_reg_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_rd, b_rd;
    logic [31:0] a_data, b_data;
    logic [1:0]  a_mode, b_mode;
    logic [4:0]  rf_rc;
    logic [31:0] rf_dataC;
    logic        rf_w_en;
    logic [1:0]  rf_w_mode;
    logic        iss_valid;
    logic [4:0]  iss_rd, chk_ra, chk_rb;
    logic        hazard_a, hazard_b;
    logic        wb_err;

    int total;
    int bad;

    // Reference model state
    bit          m_pref_b;   // B wins the next tie
    logic [31:0] m_busy;
    logic        m_wen, m_err;
    logic [4:0]  m_rc;
    logic [31:0] m_data;
    logic [1:0]  m_mode;

    // Values observed just before the clock edge of the last tick
    logic obs_ar, obs_br, obs_ha, obs_hb;

    reg_wb_arbiter #(
        .WIDTH    (32),
        .ADDR_LEN (5),
        .NUM_REGS (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_rd      (a_rd),
        .a_data    (a_data),
        .a_mode    (a_mode),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_rd      (b_rd),
        .b_data    (b_data),
        .b_mode    (b_mode),
        .rf_rc     (rf_rc),
        .rf_dataC  (rf_dataC),
        .rf_w_en   (rf_w_en),
        .rf_w_mode (rf_w_mode),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .chk_ra    (chk_ra),
        .chk_rb    (chk_rb),
        .hazard_a  (hazard_a),
        .hazard_b  (hazard_b),
        .wb_err    (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_pref_b = 1'b0;
        m_busy   = '0;
        m_wen    = 1'b0;
        m_err    = 1'b0;
        m_rc     = '0;
        m_data   = '0;
        m_mode   = '0;
    endtask

    task automatic idle();
        a_valid = 0; a_rd = 0; a_data = 0; a_mode = 0;
        b_valid = 0; b_rd = 0; b_data = 0; b_mode = 0;
        iss_valid = 0; iss_rd = 0;
    endtask

    // Advance one clock: sample combinational outputs before the edge, apply
    // the behavioural rules to the model at the edge, return 1 time unit after.
    task automatic tick();
        bit          ga, gb;
        logic [4:0]  rd;
        logic [31:0] d;
        logic [1:0]  md;
        #2;
        obs_ar = a_ready; obs_br = b_ready; obs_ha = hazard_a; obs_hb = hazard_b;
        ga = a_valid && (!b_valid || !m_pref_b);
        gb = b_valid && !ga;
        @(posedge clk);
        if (ga || gb) begin
            rd = ga ? a_rd : b_rd;
            d  = ga ? a_data : b_data;
            md = ga ? a_mode : b_mode;
            m_pref_b = ga;
            m_err = (md == 2'd3);
            if (rd != 0 && md != 2'd3) begin
                m_wen = 1; m_rc = rd; m_data = d; m_mode = md;
            end else begin
                m_wen = 0;
            end
            m_busy[rd] = 1'b0;
        end else begin
            m_wen = 0;
            m_err = 0;
        end
        if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        chk_ra = 5'd3; chk_rb = 5'd17;
        #3;
        total++; if (rf_w_en !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b exp=0", rf_w_en); end
        total++; if (rf_rc !== 5'd0) begin bad++; $display("FAIL reset_rc got=%0d exp=0", rf_rc); end
        total++; if (rf_dataC !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", rf_dataC); end
        total++; if (rf_w_mode !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d exp=0", rf_w_mode); end
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", wb_err); end
        total++; if (hazard_a !== 1'b0 || hazard_b !== 1'b0) begin
            bad++; $display("FAIL reset_hazard got=%b%b exp=00", hazard_a, hazard_b);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_a_only();
        do_reset();
        a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF; a_mode = 0;
        tick();
        total++; if (obs_ar !== 1'b1 || obs_br !== 1'b0) begin
            bad++; $display("FAIL a_only_ready got a=%b b=%b exp a=1 b=0", obs_ar, obs_br);
        end
        total++; if (rf_w_en !== 1'b1) begin bad++; $display("FAIL a_only_wen got=%b exp=1", rf_w_en); end
        total++; if (rf_rc !== 5'd5) begin bad++; $display("FAIL a_only_rc got=%0d exp=5", rf_rc); end
        total++; if (rf_dataC !== 32'hDEADBEEF) begin
            bad++; $display("FAIL a_only_data got=%h exp=deadbeef", rf_dataC);
        end
        idle();
        tick();
        total++; if (rf_w_en !== 1'b0) begin bad++; $display("FAIL a_only_pulse got=%b exp=0", rf_w_en); end
        total++; if (rf_rc !== 5'd5 || rf_dataC !== 32'hDEADBEEF) begin
            bad++; $display("FAIL a_only_hold got rc=%0d data=%h exp rc=5 data=deadbeef", rf_rc, rf_dataC);
        end
    endtask

    task automatic test_tie_fairness();
        do_reset();
        a_valid = 1; a_rd = 1; a_data = 32'h11; a_mode = 0;
        b_valid = 1; b_rd = 2; b_data = 32'h22; b_mode = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (obs_ar !== (i % 2 == 0) || obs_br !== (i % 2 == 1)) begin
                bad++; $display("FAIL tie_grant%0d got a=%b b=%b exp a=%b b=%b",
                                i, obs_ar, obs_br, i % 2 == 0, i % 2 == 1);
            end
            total++; if (rf_w_en !== 1'b1 || rf_rc !== ((i % 2 == 0) ? 5'd1 : 5'd2)) begin
                bad++; $display("FAIL tie_write%0d got wen=%b rc=%0d exp wen=1 rc=%0d",
                                i, rf_w_en, rf_rc, (i % 2 == 0) ? 1 : 2);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_scoreboard();
        do_reset();
        chk_ra = 7; chk_rb = 0;
        iss_valid = 1; iss_rd = 7;
        tick();
        total++; if (obs_ha !== 1'b0) begin bad++; $display("FAIL sb_issue_cycle got=%b exp=0", obs_ha); end
        iss_valid = 0;
        tick();
        total++; if (obs_ha !== 1'b1 || obs_hb !== 1'b0) begin
            bad++; $display("FAIL sb_after_issue got a=%b b=%b exp a=1 b=0", obs_ha, obs_hb);
        end
        b_valid = 1; b_rd = 7; b_data = 32'hCAFE0007; b_mode = 0;
        tick();
        total++; if (obs_br !== 1'b1 || obs_ha !== 1'b1) begin
            bad++; $display("FAIL sb_xfer_cycle got ready=%b haz=%b exp ready=1 haz=1", obs_br, obs_ha);
        end
        total++; if (hazard_a !== 1'b0 || rf_w_en !== 1'b1 || rf_rc !== 5'd7) begin
            bad++; $display("FAIL sb_after_xfer got haz=%b wen=%b rc=%0d exp haz=0 wen=1 rc=7",
                            hazard_a, rf_w_en, rf_rc);
        end
        idle();
        tick();
    endtask

    task automatic test_same_cycle_r0();
        do_reset();
        chk_ra = 9; chk_rb = 0;
        iss_valid = 1; iss_rd = 9;
        tick();
        a_valid = 1; a_rd = 9; a_data = 32'h99; a_mode = 0;
        tick();
        total++; if (obs_ar !== 1'b1) begin bad++; $display("FAIL same_ready got=%b exp=1", obs_ar); end
        total++; if (hazard_a !== 1'b1) begin bad++; $display("FAIL same_busy got=%b exp=1", hazard_a); end
        iss_valid = 0;
        tick();
        total++; if (hazard_a !== 1'b0) begin bad++; $display("FAIL same_clear got=%b exp=0", hazard_a); end
        a_rd = 0; a_data = 32'h1234;
        tick();
        total++; if (obs_ar !== 1'b1 || rf_w_en !== 1'b0) begin
            bad++; $display("FAIL r0_write got ready=%b wen=%b exp ready=1 wen=0", obs_ar, rf_w_en);
        end
        total++; if (rf_rc !== 5'd9 || rf_dataC !== 32'h99) begin
            bad++; $display("FAIL r0_hold got rc=%0d data=%h exp rc=9 data=99", rf_rc, rf_dataC);
        end
        idle();
        tick();
    endtask

    task automatic test_mode3();
        do_reset();
        chk_ra = 4; chk_rb = 0;
        iss_valid = 1; iss_rd = 4;
        tick();
        iss_valid = 0;
        a_valid = 1; a_rd = 4; a_data = 32'h4444; a_mode = 3;
        tick();
        total++; if (obs_ar !== 1'b1) begin bad++; $display("FAIL m3_ready got=%b exp=1", obs_ar); end
        total++; if (wb_err !== 1'b1 || rf_w_en !== 1'b0) begin
            bad++; $display("FAIL m3_err got err=%b wen=%b exp err=1 wen=0", wb_err, rf_w_en);
        end
        total++; if (hazard_a !== 1'b0) begin bad++; $display("FAIL m3_busy got=%b exp=0", hazard_a); end
        idle();
        tick();
        total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL m3_pulse got=%b exp=0", wb_err); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        chk_ra = 12; chk_rb = 0;
        iss_valid = 1; iss_rd = 12;
        tick();
        iss_valid = 0;
        a_valid = 1; a_rd = 3; a_data = 32'h33; a_mode = 0;
        tick();
        total++; if (rf_w_en !== 1'b1 || hazard_a !== 1'b1) begin
            bad++; $display("FAIL mr_pre got wen=%b haz=%b exp wen=1 haz=1", rf_w_en, hazard_a);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (rf_w_en !== 1'b0 || hazard_a !== 1'b0 || wb_err !== 1'b0) begin
            bad++; $display("FAIL mr_async got wen=%b haz=%b err=%b exp all 0", rf_w_en, hazard_a, wb_err);
        end
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_valid = 1; a_rd = 10; a_data = 32'hA0;
        b_valid = 1; b_rd = 11; b_data = 32'hB0;
        tick();
        total++; if (obs_ar !== 1'b1 || obs_br !== 1'b0 || rf_rc !== 5'd10) begin
            bad++; $display("FAIL mr_tie got a=%b b=%b rc=%0d exp a=1 b=0 rc=10", obs_ar, obs_br, rf_rc);
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        logic       exp_ar, exp_br, exp_ha, exp_hb;
        logic [4:0] r;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            // A requester holds its request until it is accepted.
            if (!a_valid || obs_ar) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_rd = 5'($urandom_range(0, 31));
                a_data = $urandom;
                a_mode = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            end
            if (!b_valid || obs_br) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_rd = 5'($urandom_range(0, 31));
                b_data = $urandom;
                b_mode = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            end
            r = 5'($urandom_range(0, 31));
            iss_valid = (!m_busy[r] && $urandom_range(0, 1) == 0);
            iss_rd = r;
            chk_ra = 5'($urandom_range(0, 31));
            chk_rb = 5'($urandom_range(0, 31));
            exp_ar = a_valid && (!b_valid || !m_pref_b);
            exp_br = b_valid && (!a_valid || m_pref_b);
            exp_ha = m_busy[chk_ra];
            exp_hb = m_busy[chk_rb];
            tick();
            total++; if (obs_ar !== exp_ar || obs_br !== exp_br) begin
                bad++; $display("FAIL rnd_ready@%0d got a=%b b=%b exp a=%b b=%b", i, obs_ar, obs_br, exp_ar, exp_br);
            end
            total++; if (obs_ha !== exp_ha || obs_hb !== exp_hb) begin
                bad++; $display("FAIL rnd_hazard@%0d got a=%b b=%b exp a=%b b=%b", i, obs_ha, obs_hb, exp_ha, exp_hb);
            end
            total++; if (rf_w_en !== m_wen || wb_err !== m_err) begin
                bad++; $display("FAIL rnd_wen@%0d got wen=%b err=%b exp wen=%b err=%b", i, rf_w_en, wb_err, m_wen, m_err);
            end
            total++; if (rf_rc !== m_rc || rf_dataC !== m_data || rf_w_mode !== m_mode) begin
                bad++; $display("FAIL rnd_port@%0d got rc=%0d data=%h mode=%0d exp rc=%0d data=%h mode=%0d",
                                i, rf_rc, rf_dataC, rf_w_mode, m_rc, m_data, m_mode);
            end
        end
        idle();
        tick();
    endtask

    initial begin
        total = 0;
        bad = 0;
        obs_ar = 0; obs_br = 0; obs_ha = 0; obs_hb = 0;
        chk_ra = 0; chk_rb = 0;
        idle();
        model_reset();
        rst_n = 1'b1;
        #1;
        test_reset();
        test_a_only();
        test_tie_fairness();
        test_scoreboard();
        test_same_cycle_r0();
        test_mode3();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
